// File: rtl/eth_pkg.sv
// Shared constants and state type for the Ethernet receive path.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [47:0] ETH_BCAST    = 48'hFFFF_FFFF_FFFF;

    localparam logic [31:0] CRC_POLY     = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT     = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB_20E3;

    localparam int unsigned ETH_MAC_LEN   = 6;
    localparam int unsigned ETH_HDR_LEN   = 14;
    localparam int unsigned ETH_FCS_LEN   = 4;
    // One slot beyond the FCS so the FCS never reaches the payload output.
    localparam int unsigned ETH_DLY_DEPTH = ETH_FCS_LEN + 1;

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StHeader,
        StPayload,
        StDrop
    } rx_state_e;

endpackage

// File: rtl/eth_frame_rx_if.sv
// Receive byte stream in, parsed header and payload stream out.
interface eth_frame_rx_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_err;

    logic        hdr_valid;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_last;
    logic        frame_done;
    logic        frame_ok;

    modport master (
        output rx_data, rx_valid, rx_err,
        input  hdr_valid, src_mac, eth_type, pay_data, pay_valid, pay_last,
        input  frame_done, frame_ok
    );

    modport slave (
        input  rx_data, rx_valid, rx_err,
        output hdr_valid, src_mac, eth_type, pay_data, pay_valid, pay_last,
        output frame_done, frame_ok
    );

endinterface

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte update of the reflected Ethernet CRC32 register.
module eth_crc32_byte
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            crc_out = (crc_out >> 1) ^ ((crc_out[0] ^ data[i]) ? CRC_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/eth_frame_rx.sv
// Ethernet RX frame parser: preamble strip, MAC filter, header capture, FCS-less payload.
// Define ETH_RX_PROMISC_EN to disable the destination MAC filter.
module eth_frame_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
    parameter int unsigned MIN_FRAME = 64,
    parameter int unsigned MAX_FRAME = 1518
) (
    input logic           clk,
    input logic           rst,
    eth_frame_rx_if.slave bus
);

    localparam logic [15:0] MinLen  = 16'(MIN_FRAME);
    localparam logic [15:0] MaxLen  = 16'(MAX_FRAME);
    localparam logic [15:0] MacLen  = 16'(ETH_MAC_LEN);
    localparam logic [15:0] HdrLen  = 16'(ETH_HDR_LEN);
    localparam logic [2:0]  DlyFull = 3'(ETH_DLY_DEPTH);

    rx_state_e state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [31:0] crc_q, crc_d, crc_next;
    logic        err_q, err_d;
    logic        gap_q, gap_d;
    logic [55:0] sr_q, sr_d;
    logic [2:0]  fill_q, fill_d;
    logic [ETH_DLY_DEPTH-1:0][7:0] dly_q, dly_d;

    logic        hdr_valid_q, hdr_valid_d;
    logic [47:0] src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [7:0]  pay_data_q, pay_data_d;
    logic        pay_valid_q, pay_valid_d;
    logic        pay_last_q, pay_last_d;
    logic        done_q, done_d;
    logic        ok_q, ok_d;
    logic        dst_ok;

    eth_crc32_byte u_crc (
        .crc_in  (crc_q),
        .data    (bus.rx_data),
        .crc_out (crc_next)
    );

    assign cnt_inc = cnt_q + 16'd1;

`ifdef ETH_RX_PROMISC_EN
    assign dst_ok = 1'b1;
`else
    logic [47:0] dst_mac;
    assign dst_mac = {sr_q[39:0], bus.rx_data};
    assign dst_ok  = (dst_mac == LOCAL_MAC) || (dst_mac == ETH_BCAST);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        crc_d       = crc_q;
        err_d       = err_q;
        // A frame may only start after rx_valid has been seen low since reset.
        gap_d       = gap_q | ~bus.rx_valid;
        sr_d        = sr_q;
        fill_d      = fill_q;
        dly_d       = dly_q;
        src_d       = src_q;
        type_d      = type_q;
        pay_data_d  = pay_data_q;
        hdr_valid_d = 1'b0;
        pay_valid_d = 1'b0;
        pay_last_d  = 1'b0;
        done_d      = 1'b0;
        ok_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.rx_valid) begin
                    state_d = (gap_q && bus.rx_data == ETH_PREAMBLE) ? StPreamble : StDrop;
                end
            end
            StPreamble: begin
                if (!bus.rx_valid) begin
                    state_d = StIdle;
                end else if (bus.rx_data == ETH_SFD) begin
                    state_d = StHeader;
                    crc_d   = CRC_INIT;
                    cnt_d   = 16'd0;
                    err_d   = 1'b0;
                    fill_d  = 3'd0;
                end else if (bus.rx_data != ETH_PREAMBLE) begin
                    state_d = StDrop;
                end
            end
            StHeader: begin
                if (!bus.rx_valid) begin
                    state_d = StIdle;
                end else begin
                    crc_d = crc_next;
                    cnt_d = cnt_inc;
                    err_d = err_q | bus.rx_err;
                    sr_d  = {sr_q[47:0], bus.rx_data};
                    if (cnt_inc == MacLen && !dst_ok) begin
                        state_d = StDrop;
                    end else if (cnt_inc == HdrLen) begin
                        state_d         = StPayload;
                        hdr_valid_d     = 1'b1;
                        {src_d, type_d} = {sr_q, bus.rx_data};
                    end
                end
            end
            StPayload: begin
                if (!bus.rx_valid) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (fill_q == DlyFull) begin
                        pay_valid_d = 1'b1;
                        pay_last_d  = 1'b1;
                        pay_data_d  = dly_q[ETH_DLY_DEPTH-1];
                        ok_d        = (crc_q == CRC_RESIDUE) && !err_q && (cnt_q >= MinLen);
                    end
                end else if (cnt_inc > MaxLen) begin
                    state_d = StDrop;
                    done_d  = 1'b1;
                end else begin
                    crc_d = crc_next;
                    cnt_d = cnt_inc;
                    err_d = err_q | bus.rx_err;
                    dly_d = {dly_q[ETH_DLY_DEPTH-2:0], bus.rx_data};
                    if (fill_q == DlyFull) begin
                        pay_valid_d = 1'b1;
                        pay_data_d  = dly_q[ETH_DLY_DEPTH-1];
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
            end
            StDrop: begin
                if (!bus.rx_valid) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            cnt_q       <= 16'd0;
            crc_q       <= CRC_INIT;
            err_q       <= 1'b0;
            gap_q       <= 1'b0;
            sr_q        <= '0;
            fill_q      <= 3'd0;
            dly_q       <= '0;
            hdr_valid_q <= 1'b0;
            src_q       <= 48'd0;
            type_q      <= 16'd0;
            pay_data_q  <= 8'd0;
            pay_valid_q <= 1'b0;
            pay_last_q  <= 1'b0;
            done_q      <= 1'b0;
            ok_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            crc_q       <= crc_d;
            err_q       <= err_d;
            gap_q       <= gap_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            dly_q       <= dly_d;
            hdr_valid_q <= hdr_valid_d;
            src_q       <= src_d;
            type_q      <= type_d;
            pay_data_q  <= pay_data_d;
            pay_valid_q <= pay_valid_d;
            pay_last_q  <= pay_last_d;
            done_q      <= done_d;
            ok_q        <= ok_d;
        end
    end

    assign bus.hdr_valid  = hdr_valid_q;
    assign bus.src_mac    = src_q;
    assign bus.eth_type   = type_q;
    assign bus.pay_data   = pay_data_q;
    assign bus.pay_valid  = pay_valid_q;
    assign bus.pay_last   = pay_last_q;
    assign bus.frame_done = done_q;
    assign bus.frame_ok   = ok_q;

endmodule

// File: tb/tb_eth_frame_rx.sv
// Randomized + directed bench for eth_frame_rx against a frame-level event model.
module tb_eth_frame_rx;

    localparam logic [47:0] LocalMac = 48'h02_00_00_00_00_01;
    localparam logic [47:0] Bcast    = 48'hFFFF_FFFF_FFFF;
    localparam int          MaxLen   = 1518;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #4 clk = ~clk;

    eth_frame_rx_if bus ();

    eth_frame_rx #(
        .LOCAL_MAC (LocalMac),
        .MIN_FRAME (64),
        .MAX_FRAME (MaxLen)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          t;
        logic [63:0] v;
    } ev_t;

    ev_t exp_hdr[$];
    ev_t exp_pay[$];
    ev_t exp_done[$];

    int n_hdr = 0, n_pay = 0, n_done = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_ok = 1'b0;
    int b_hdr, b_pay, b_done;
    int model_pay_n;
    logic model_ok;

    logic [7:0] frm[$];
    bit         ferr[$];
    int         g_pre;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference CRC32 (IEEE 802.3): init all-ones, reflected, final inversion.
    function automatic logic [31:0] crc32_range(input logic [7:0] w[$], input int a, input int b);
        logic [31:0] c = 32'hFFFF_FFFF;
        for (int i = a; i <= b; i++) begin
            c = c ^ {24'h0, w[i]};
            for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic push_ev(input int kind, input int t, input logic [63:0] v, input int tcut);
        ev_t e;
        if (t > tcut) return;
        e.t = t;
        e.v = v;
        case (kind)
            0: exp_hdr.push_back(e);
            1: begin exp_pay.push_back(e); model_pay_n++; end
            default: begin exp_done.push_back(e); model_ok = v[0]; end
        endcase
    endtask

    // Expected events for a wire byte sequence driven from cycle c0; byte i is visible
    // at the outputs one cycle after it is driven. ri >= 0: reset during byte ri.
    task automatic model(input logic [7:0] w[$], input bit e[$], input int c0, input int ri);
        int L, s, n, lim, tcut;
        logic [47:0] dst;
        logic [63:0] hv;
        logic [31:0] fcs;
        bit acc, err;
        model_pay_n = 0;
        model_ok = 1'b0;
        L = w.size();
        tcut = (ri >= 0) ? c0 + ri : 32'h7FFF_FFFF;
        if (L == 0 || w[0] != 8'h55) return;
        s = 1;
        while (s < L && w[s] == 8'h55) s++;
        if (s >= L || w[s] != 8'hD5) return;
        n = L - 1 - s;
        if (n < 14) return;
        for (int k = 1; k <= 6; k++) dst = {dst[39:0], w[s+k]};
`ifdef ETH_RX_PROMISC_EN
        acc = 1'b1;
`else
        acc = (dst == LocalMac) || (dst == Bcast);
`endif
        if (!acc) return;
        for (int k = 7; k <= 14; k++) hv = {hv[55:0], w[s+k]};
        push_ev(0, c0 + s + 15, hv, tcut);
        lim = (n > MaxLen) ? MaxLen : n;
        for (int k = 20; k <= lim; k++) push_ev(1, c0 + s + k + 1, {56'h0, w[s+k-5]}, tcut);
        if (n > MaxLen) begin
            push_ev(2, c0 + s + MaxLen + 2, 64'h0, tcut);
        end else begin
            err = 1'b0;
            for (int k = 1; k <= n; k++) err = err | e[s+k];
            fcs = {w[s+n], w[s+n-1], w[s+n-2], w[s+n-3]};
            if (n >= 19) push_ev(1, c0 + L + 1, {55'h0, 1'b1, w[s+n-4]}, tcut);
            acc = (n >= 64) && !err && (fcs == crc32_range(w, s + 1, s + n - 4));
            push_ev(2, c0 + L + 1, {63'h0, acc}, tcut);
        end
    endtask

    task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                         input int plen, input int pre, input bit rnd);
        logic [31:0] c;
        frm = {};
        ferr = {};
        g_pre = pre;
        repeat (pre) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) frm.push_back(dst[8*i +: 8]);
        for (int i = 5; i >= 0; i--) frm.push_back(src[8*i +: 8]);
        frm.push_back(typ[15:8]);
        frm.push_back(typ[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i));
        c = crc32_range(frm, pre + 1, frm.size() - 1);
        for (int i = 0; i < 4; i++) frm.push_back(c[8*i +: 8]);
        for (int i = 0; i < frm.size(); i++) ferr.push_back(1'b0);
    endtask

    task automatic drive(input logic [7:0] w[$], input bit e[$], input int ri);
        int c0;
        c0 = cyc;
        model(w, e, c0, ri);
        for (int i = 0; i < w.size(); i++) begin
            bus.rx_valid = 1'b1;
            bus.rx_data  = w[i];
            bus.rx_err   = e[i];
            rst          = (i == ri) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        bus.rx_valid = 1'b0;
        bus.rx_err   = 1'b0;
        rst          = 1'b1;
        repeat (8) begin @(posedge clk); #1; end
    endtask

    task automatic snap();
        b_hdr = n_hdr;
        b_pay = n_pay;
        b_done = n_done;
    endtask

    task automatic counts(input string tag, input int eh, input int ep, input int ed);
        check({tag, "_hdr_count"},  64'(n_hdr - b_hdr),   64'(eh));
        check({tag, "_pay_count"},  64'(n_pay - b_pay),   64'(ep));
        check({tag, "_done_count"}, 64'(n_done - b_done), 64'(ed));
    endtask

    // Event-by-event comparison of all valid-qualified outputs against the model.
    logic hx, px, dx;
    always @(negedge clk) begin
        hx = exp_hdr.size() > 0 && exp_hdr[0].t == cyc;
        if (hx || bus.hdr_valid) check("hdr_valid", 64'(bus.hdr_valid), 64'(hx));
        if (hx && bus.hdr_valid) check("hdr_fields", {bus.src_mac, bus.eth_type}, exp_hdr[0].v);
        if (hx) void'(exp_hdr.pop_front());

        px = exp_pay.size() > 0 && exp_pay[0].t == cyc;
        if (px || bus.pay_valid) check("pay_valid", 64'(bus.pay_valid), 64'(px));
        if (px && bus.pay_valid) check("pay_byte", 64'({bus.pay_last, bus.pay_data}), exp_pay[0].v);
        if (px) void'(exp_pay.pop_front());

        dx = exp_done.size() > 0 && exp_done[0].t == cyc;
        if (dx || bus.frame_done) check("frame_done", 64'(bus.frame_done), 64'(dx));
        if (dx && bus.frame_done) check("frame_ok", 64'(bus.frame_ok), exp_done[0].v);
        if (dx) void'(exp_done.pop_front());

        if (bus.hdr_valid) n_hdr++;
        if (bus.pay_valid) n_pay++;
        if (bus.pay_valid && bus.pay_last) last_data = bus.pay_data;
        if (bus.frame_done) begin n_done++; last_ok = bus.frame_ok; end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        logic [7:0] kat[$];
        logic [47:0] src1 = 48'h0A_0B_0C_0D_0E_0F;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_err   = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", 64'({bus.hdr_valid, bus.pay_valid, bus.pay_last, bus.frame_done,
                                  bus.frame_ok, bus.pay_data}), 64'h0);
        check("reset_src_type", {bus.src_mac, bus.eth_type}, 64'h0);
        rst = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        for (int i = 0; i < 9; i++) kat.push_back(8'h31 + 8'(i));
        check("model_crc_kat", 64'(crc32_range(kat, 0, 8)), 64'hCBF4_3926);

        // 1: minimum good frame to the local station
        build(LocalMac, src1, 16'h0800, 46, 7, 1'b0);
        snap(); drive(frm, ferr, -1);
        check("t1_model_pay", 64'(model_pay_n), 64'd46);
        check("t1_model_ok", 64'(model_ok), 64'd1);
        counts("t1", 1, 46, 1);
        check("t1_last_byte", 64'(last_data), 64'h2D);
        check("t1_ok", 64'(last_ok), 64'd1);
        check("t1_src", 64'(bus.src_mac), 64'(src1));
        check("t1_type", 64'(bus.eth_type), 64'h0800);

        // 2: single payload bit error
        build(LocalMac, src1, 16'h0800, 46, 7, 1'b0);
        frm[g_pre + 25] ^= 8'h10;
        snap(); drive(frm, ferr, -1);
        counts("t2", 1, 46, 1);
        check("t2_ok", 64'(last_ok), 64'd0);

        // 3: foreign destination
        build(48'h02_00_00_00_00_99, src1, 16'h0800, 46, 7, 1'b0);
        snap(); drive(frm, ferr, -1);
`ifdef ETH_RX_PROMISC_EN
        counts("t3", 1, 46, 1);
        check("t3_ok", 64'(last_ok), 64'd1);
`else
        counts("t3", 0, 0, 0);
`endif

        // 4: broadcast with PHY error on frame byte 30
        build(Bcast, src1, 16'h0806, 46, 7, 1'b1);
        ferr[g_pre + 30] = 1'b1;
        snap(); drive(frm, ferr, -1);
        counts("t4", 1, 46, 1);
        check("t4_ok", 64'(last_ok), 64'd0);

        // 5: truncated inside the header, then a good frame
        build(LocalMac, src1, 16'h0800, 46, 7, 1'b1);
        while (frm.size() > g_pre + 9) begin void'(frm.pop_back()); void'(ferr.pop_back()); end
        snap(); drive(frm, ferr, -1);
        counts("t5_trunc", 0, 0, 0);
        build(LocalMac, src1, 16'h0800, 46, 7, 1'b1);
        snap(); drive(frm, ferr, -1);
        counts("t5_next", 1, 46, 1);
        check("t5_ok", 64'(last_ok), 64'd1);

        // 6: reset mid-payload with rx_valid held, recovery, then oversize frame
        build(LocalMac, src1, 16'h0800, 46, 7, 1'b1);
        snap(); drive(frm, ferr, g_pre + 30);
        counts("t6_abort", 1, 10, 0);
        check("t6_src_cleared", 64'(bus.src_mac), 64'h0);
        build(LocalMac, src1, 16'h86DD, 46, 7, 1'b1);
        snap(); drive(frm, ferr, -1);
        counts("t6_next", 1, 46, 1);
        check("t6_ok", 64'(last_ok), 64'd1);
        build(LocalMac, src1, 16'h0800, 1600 - 18, 7, 1'b1);
        snap(); drive(frm, ferr, -1);
        counts("t6_big", 1, 1499, 1);
        check("t6_big_ok", 64'(last_ok), 64'd0);

        // Length boundaries: 63 bytes rejected, 1518 bytes accepted
        build(LocalMac, src1, 16'h0800, 45, 3, 1'b1);
        snap(); drive(frm, ferr, -1);
        counts("len63", 1, 45, 1);
        check("len63_ok", 64'(last_ok), 64'd0);
        build(Bcast, src1, 16'h0800, 1500, 7, 1'b1);
        snap(); drive(frm, ferr, -1);
        counts("len1518", 1, 1500, 1);
        check("len1518_ok", 64'(last_ok), 64'd1);

        for (int it = 0; it < 40; it++) begin
            int sel, idx;
            logic [47:0] d;
            sel = $urandom_range(0, 3);
            d = (sel == 1) ? Bcast : (sel == 2) ? {16'($urandom), $urandom} : LocalMac;
            build(d, {16'($urandom), $urandom}, 16'($urandom), $urandom_range(0, 80),
                  $urandom_range(1, 7), 1'b1);
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(g_pre + 1, frm.size() - 1);
                frm[idx] ^= 8'(1 << $urandom_range(0, 7));
            end
            if ($urandom_range(0, 5) == 0) ferr[$urandom_range(g_pre + 1, frm.size() - 1)] = 1'b1;
            if ($urandom_range(0, 9) == 0) frm[$urandom_range(0, g_pre - 1)] = 8'h12;
            if ($urandom_range(0, 7) == 0) begin
                idx = $urandom_range(g_pre + 1, frm.size() - 1);
                while (frm.size() > idx) begin void'(frm.pop_back()); void'(ferr.pop_back()); end
            end
            drive(frm, ferr, -1);
        end

        check("left_hdr", 64'(exp_hdr.size()), 64'd0);
        check("left_pay", 64'(exp_pay.size()), 64'd0);
        check("left_done", 64'(exp_done.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
